// File: rtl/trap_ctrl_pkg.sv
// Shared constants, state encoding and mstatus update helpers for the trap sequencer.
package trap_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
    localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
    localparam logic [31:0] CAUSE_ECALL   = 32'd11;
    localparam logic [31:0] CAUSE_MEI     = 32'h8000_000B;
    localparam logic [31:0] CAUSE_MSI     = 32'h8000_0003;
    localparam logic [31:0] CAUSE_MTI     = 32'h8000_0007;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_W_MEPC    = 3'd1,
        ST_W_MCAUSE  = 3'd2,
        ST_W_MTVAL   = 3'd3,
        ST_W_MSTATUS = 3'd4,
        ST_T_JUMP    = 3'd5,
        ST_R_MSTATUS = 3'd6,
        ST_R_JUMP    = 3'd7
    } trap_state_e;

    // Trap entry: MPIE takes the old MIE, MIE is cleared.
    function automatic logic [31:0] mstatus_on_trap(input logic [31:0] cur);
        logic [31:0] res;
        res    = cur;
        res[7] = cur[3];
        res[3] = 1'b0;
        return res;
    endfunction

    // Trap return: MIE takes MPIE, MPIE is set.
    function automatic logic [31:0] mstatus_on_mret(input logic [31:0] cur);
        logic [31:0] res;
        res    = cur;
        res[3] = cur[7];
        res[7] = 1'b1;
        return res;
    endfunction

endpackage

// File: rtl/trap_ctrl_prio.sv
// Combinational priority encoder: picks the trap or mret to accept and forms cause/epc/tval.
module trap_ctrl_prio
    import trap_ctrl_pkg::*;
(
    input  logic        hx_valid,
    input  logic        mie,
    input  logic        illegal,
    input  logic        ebreak,
    input  logic        ecall,
    input  logic        mret,
    input  logic        ex_irq,
    input  logic        soft_irq,
    input  logic        tcmp_irq,
    input  logic [31:0] pc,
    input  logic [31:0] next_pc,
    input  logic [31:0] inst,
    output logic        take_trap,
    output logic        take_mret,
    output logic [31:0] cause,
    output logic [31:0] epc,
    output logic [31:0] tval
);

    // Exceptions beat mret, mret beats interrupts.
    always_comb begin
        take_trap = 1'b0;
        take_mret = 1'b0;
        cause     = 32'd0;
        epc       = 32'd0;
        tval      = 32'd0;
        if (!hx_valid) begin
            take_trap = 1'b0;
        end else if (illegal) begin
            take_trap = 1'b1;
            cause     = CAUSE_ILLEGAL;
            epc       = pc;
            tval      = inst;
        end else if (ebreak) begin
            take_trap = 1'b1;
            cause     = CAUSE_EBREAK;
            epc       = pc;
            tval      = pc;
        end else if (ecall) begin
            take_trap = 1'b1;
            cause     = CAUSE_ECALL;
            epc       = pc;
        end else if (mret) begin
            take_mret = 1'b1;
        end else if (mie && ex_irq) begin
            take_trap = 1'b1;
            cause     = CAUSE_MEI;
            epc       = next_pc;
        end else if (mie && soft_irq) begin
            take_trap = 1'b1;
            cause     = CAUSE_MSI;
            epc       = next_pc;
        end else if (mie && tcmp_irq) begin
            take_trap = 1'b1;
            cause     = CAUSE_MTI;
            epc       = next_pc;
        end else begin
            take_trap = 1'b0;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: writes mepc/mcause/mtval/mstatus on trap entry and mstatus on mret,
// then redirects fetch; stalls the pipeline while it owns the trap CSR channel.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter bit VECTORED_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hx_valid,
    input  logic [31:0] pc_i,
    input  logic [31:0] next_pc_i,
    input  logic [31:0] inst_i,
    input  logic        ecall_i,
    input  logic        ebreak_i,
    input  logic        illegal_i,
    input  logic        mret_i,
    input  logic        ex_trap_valid_i,
    input  logic        soft_trap_valid_i,
    input  logic        tcmp_trap_valid_i,
    input  logic        mstatus_MIE3_i,
    output logic        trap_csr_we_o,
    output logic [11:0] trap_csr_addr_o,
    output logic [31:0] trap_csr_wdata_o,
    input  logic [31:0] trap_csr_rdata_i,
    output logic        hold_o,
    output logic        trap_jump_o,
    output logic [31:0] trap_jump_addr_o
);

    trap_state_e state_r, state_next_s;
    logic [31:0] cause_r, epc_r, tval_r;
    logic        take_trap_s, take_mret_s, accept_en_s;
    logic [31:0] cause_s, epc_s, tval_s;
    logic [31:0] base_s, vec_off_s;

    trap_ctrl_prio u_prio (
        .hx_valid  (hx_valid),
        .mie       (mstatus_MIE3_i),
        .illegal   (illegal_i),
        .ebreak    (ebreak_i),
        .ecall     (ecall_i),
        .mret      (mret_i),
        .ex_irq    (ex_trap_valid_i),
        .soft_irq  (soft_trap_valid_i),
        .tcmp_irq  (tcmp_trap_valid_i),
        .pc        (pc_i),
        .next_pc   (next_pc_i),
        .inst      (inst_i),
        .take_trap (take_trap_s),
        .take_mret (take_mret_s),
        .cause     (cause_s),
        .epc       (epc_s),
        .tval      (tval_s)
    );

    // A request held during reset must not show up as a stall.
    assign accept_en_s = (state_r == ST_IDLE) && rst_n;
    assign base_s      = {trap_csr_rdata_i[31:2], 2'b00};
    assign vec_off_s   = {1'b0, cause_r[30:0]} << 2;

    // State register and trap context latches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cause_r <= 32'd0;
            epc_r   <= 32'd0;
            tval_r  <= 32'd0;
        end else begin
            state_r <= state_next_s;
            if (accept_en_s && take_trap_s) begin
                cause_r <= cause_s;
                epc_r   <= epc_s;
                tval_r  <= tval_s;
            end else begin
                cause_r <= cause_r;
                epc_r   <= epc_r;
                tval_r  <= tval_r;
            end
        end
    end

    // Next-state and CSR channel / redirect outputs.
    always_comb begin
        state_next_s     = state_r;
        trap_csr_we_o    = 1'b0;
        trap_csr_addr_o  = 12'h000;
        trap_csr_wdata_o = 32'd0;
        trap_jump_o      = 1'b0;
        trap_jump_addr_o = 32'd0;
        hold_o           = (state_r != ST_IDLE) || (accept_en_s && (take_trap_s || take_mret_s));
        case (state_r)
            ST_IDLE: begin
                if (accept_en_s && take_trap_s) begin
                    state_next_s = ST_W_MEPC;
                end else if (accept_en_s && take_mret_s) begin
                    state_next_s = ST_R_MSTATUS;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_W_MEPC: begin
                trap_csr_we_o    = 1'b1;
                trap_csr_addr_o  = CSR_MEPC;
                trap_csr_wdata_o = epc_r;
                state_next_s     = ST_W_MCAUSE;
            end
            ST_W_MCAUSE: begin
                trap_csr_we_o    = 1'b1;
                trap_csr_addr_o  = CSR_MCAUSE;
                trap_csr_wdata_o = cause_r;
                state_next_s     = ST_W_MTVAL;
            end
            ST_W_MTVAL: begin
                trap_csr_we_o    = 1'b1;
                trap_csr_addr_o  = CSR_MTVAL;
                trap_csr_wdata_o = tval_r;
                state_next_s     = ST_W_MSTATUS;
            end
            ST_W_MSTATUS: begin
                trap_csr_we_o    = 1'b1;
                trap_csr_addr_o  = CSR_MSTATUS;
                trap_csr_wdata_o = mstatus_on_trap(trap_csr_rdata_i);
                state_next_s     = ST_T_JUMP;
            end
            ST_T_JUMP: begin
                trap_csr_addr_o = CSR_MTVEC;
                trap_jump_o     = 1'b1;
                // Vectored mode applies only to interrupts (cause MSB set).
                if (VECTORED_EN && cause_r[31] && (trap_csr_rdata_i[1:0] == 2'b01)) begin
                    trap_jump_addr_o = base_s + vec_off_s;
                end else begin
                    trap_jump_addr_o = base_s;
                end
                state_next_s = ST_IDLE;
            end
            ST_R_MSTATUS: begin
                trap_csr_we_o    = 1'b1;
                trap_csr_addr_o  = CSR_MSTATUS;
                trap_csr_wdata_o = mstatus_on_mret(trap_csr_rdata_i);
                state_next_s     = ST_R_JUMP;
            end
            ST_R_JUMP: begin
                trap_csr_addr_o  = CSR_MEPC;
                trap_jump_o      = 1'b1;
                trap_jump_addr_o = base_s;
                state_next_s     = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: a small CSR file answers the trap channel and a
// spec-level model predicts accepted operation, CSR writes, redirect timing and target.
module tb_trap_ctrl;

    typedef struct packed {
        logic [11:0] a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hx_valid;
    logic [31:0] pc_i, next_pc_i, inst_i;
    logic        ecall_i, ebreak_i, illegal_i, mret_i;
    logic        ex_trap_valid_i, soft_trap_valid_i, tcmp_trap_valid_i;
    logic        mstatus_MIE3_i;
    logic        trap_csr_we_o;
    logic [11:0] trap_csr_addr_o;
    logic [31:0] trap_csr_wdata_o;
    logic [31:0] trap_csr_rdata_i;
    logic        hold_o, trap_jump_o;
    logic [31:0] trap_jump_addr_o;

    logic [31:0] csr_mstatus, csr_mtvec, csr_mepc, csr_mcause, csr_mtval;
    logic        ld_en;
    logic [31:0] ld_mstatus, ld_mtvec, ld_mepc;
    wr_t         wlog[$];

    int checks   = 0;
    int failures = 0;

    trap_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .hx_valid          (hx_valid),
        .pc_i              (pc_i),
        .next_pc_i         (next_pc_i),
        .inst_i            (inst_i),
        .ecall_i           (ecall_i),
        .ebreak_i          (ebreak_i),
        .illegal_i         (illegal_i),
        .mret_i            (mret_i),
        .ex_trap_valid_i   (ex_trap_valid_i),
        .soft_trap_valid_i (soft_trap_valid_i),
        .tcmp_trap_valid_i (tcmp_trap_valid_i),
        .mstatus_MIE3_i    (mstatus_MIE3_i),
        .trap_csr_we_o     (trap_csr_we_o),
        .trap_csr_addr_o   (trap_csr_addr_o),
        .trap_csr_wdata_o  (trap_csr_wdata_o),
        .trap_csr_rdata_i  (trap_csr_rdata_i),
        .hold_o            (hold_o),
        .trap_jump_o       (trap_jump_o),
        .trap_jump_addr_o  (trap_jump_addr_o)
    );

    always #5 clk = ~clk;

    assign mstatus_MIE3_i = csr_mstatus[3];

    // CSR block model: combinational read, write at the clock edge, plus a backdoor load.
    always_comb begin
        case (trap_csr_addr_o)
            12'h300: trap_csr_rdata_i = csr_mstatus;
            12'h305: trap_csr_rdata_i = csr_mtvec;
            12'h341: trap_csr_rdata_i = csr_mepc;
            12'h342: trap_csr_rdata_i = csr_mcause;
            12'h343: trap_csr_rdata_i = csr_mtval;
            default: trap_csr_rdata_i = 32'd0;
        endcase
    end

    always @(posedge clk) begin
        if (ld_en) begin
            csr_mstatus <= ld_mstatus;
            csr_mtvec   <= ld_mtvec;
            csr_mepc    <= ld_mepc;
            csr_mcause  <= 32'd0;
            csr_mtval   <= 32'd0;
        end else if (trap_csr_we_o) begin
            wlog.push_back('{a: trap_csr_addr_o, d: trap_csr_wdata_o});
            case (trap_csr_addr_o)
                12'h300: csr_mstatus <= trap_csr_wdata_o;
                12'h305: csr_mtvec   <= trap_csr_wdata_o;
                12'h341: csr_mepc    <= trap_csr_wdata_o;
                12'h342: csr_mcause  <= trap_csr_wdata_o;
                12'h343: csr_mtval   <= trap_csr_wdata_o;
                default: ;
            endcase
        end
    end

    task automatic clear_inputs();
        hx_valid = 1'b0; pc_i = 32'd0; next_pc_i = 32'd0; inst_i = 32'd0;
        ecall_i = 1'b0; ebreak_i = 1'b0; illegal_i = 1'b0; mret_i = 1'b0;
        ex_trap_valid_i = 1'b0; soft_trap_valid_i = 1'b0; tcmp_trap_valid_i = 1'b0;
    endtask

    task automatic preload(input logic [31:0] ms, input logic [31:0] tv, input logic [31:0] ep);
        @(negedge clk);
        ld_mstatus = ms; ld_mtvec = tv; ld_mepc = ep; ld_en = 1'b1;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Drive one retiring instruction and verify the whole resulting sequence.
    task automatic exercise_op(input logic ill, input logic ebk, input logic ecl, input logic mrt,
                               input logic ext, input logic sft, input logic tcm,
                               input logic [31:0] pc, input logic [31:0] npc,
                               input logic [31:0] inst, input string tag);
        int          kind, exp_k, got_k, base, nw;
        logic [31:0] cause, epc, tval, target, got_addr, old_ms;
        logic [11:0] ea[4];
        logic [31:0] ed[4];
        logic        mie;
        wr_t         w;
        mie = csr_mstatus[3]; old_ms = csr_mstatus;
        kind = 0; cause = 32'd0; epc = 32'd0; tval = 32'd0;
        if (ill)              begin kind = 1; cause = 32'd2;  epc = pc;  tval = inst; end
        else if (ebk)         begin kind = 1; cause = 32'd3;  epc = pc;  tval = pc;   end
        else if (ecl)         begin kind = 1; cause = 32'd11; epc = pc;               end
        else if (mrt)         begin kind = 2;                                         end
        else if (mie && ext)  begin kind = 1; cause = 32'h8000000B; epc = npc;        end
        else if (mie && sft)  begin kind = 1; cause = 32'h80000003; epc = npc;        end
        else if (mie && tcm)  begin kind = 1; cause = 32'h80000007; epc = npc;        end
        if (kind == 1) begin
            exp_k = 5; nw = 4;
            target = csr_mtvec & ~32'd3;
            if (cause[31] && csr_mtvec[1:0] == 2'd1)
                target = target + 32'd4 * (cause & 32'h7FFFFFFF);
            ea[0] = 12'h341; ed[0] = epc;
            ea[1] = 12'h342; ed[1] = cause;
            ea[2] = 12'h343; ed[2] = tval;
            ea[3] = 12'h300; ed[3] = (old_ms & ~32'h88) | (old_ms[3] ? 32'h80 : 32'h0);
        end else begin
            exp_k = 2; nw = (kind == 2) ? 1 : 0;
            target = csr_mepc & ~32'd3;
            ea[0] = 12'h300; ed[0] = (old_ms & ~32'h08) | (old_ms[7] ? 32'h08 : 32'h0) | 32'h80;
        end
        @(negedge clk);
        hx_valid = 1'b1; illegal_i = ill; ebreak_i = ebk; ecall_i = ecl; mret_i = mrt;
        ex_trap_valid_i = ext; soft_trap_valid_i = sft; tcmp_trap_valid_i = tcm;
        pc_i = pc; next_pc_i = npc; inst_i = inst;
        #1;
        checks++;
        if (hold_o !== (kind != 0)) begin
            failures++;
            $display("FAIL %s accept_hold: got %b want %b", tag, hold_o, (kind != 0));
        end
        base = wlog.size();
        @(negedge clk);
        clear_inputs();
        #1;
        if (kind == 0) begin
            checks++;
            if (hold_o !== 1'b0 || trap_csr_we_o !== 1'b0) begin
                failures++;
                $display("FAIL %s idle_after_none: hold %b we %b want 0 0", tag, hold_o, trap_csr_we_o);
            end
            return;
        end
        got_k = 0; got_addr = 32'd0;
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) begin @(negedge clk); #1; end
            checks++;
            if (hold_o !== 1'b1) begin
                failures++;
                $display("FAIL %s busy_hold cycle %0d: got %b want 1", tag, k, hold_o);
            end
            if (trap_jump_o === 1'b1) begin got_k = k; got_addr = trap_jump_addr_o; break; end
        end
        checks++;
        if (got_k != exp_k) begin
            failures++;
            $display("FAIL %s jump_cycle: got T+%0d want T+%0d", tag, got_k, exp_k);
        end
        checks++;
        if (got_addr !== target) begin
            failures++;
            $display("FAIL %s jump_addr: got %h want %h", tag, got_addr, target);
        end
        checks++;
        if (wlog.size() - base != nw) begin
            failures++;
            $display("FAIL %s write_count: got %0d want %0d", tag, wlog.size() - base, nw);
        end else begin
            for (int i = 0; i < nw; i++) begin
                w = wlog[base + i];
                checks++;
                if (w.a !== ea[i] || w.d !== ed[i]) begin
                    failures++;
                    $display("FAIL %s write%0d: got %h=%h want %h=%h", tag, i, w.a, w.d, ea[i], ed[i]);
                end
            end
        end
        @(negedge clk); #1;
        checks++;
        if (hold_o !== 1'b0 || trap_jump_o !== 1'b0 || trap_csr_addr_o !== 12'h000) begin
            failures++;
            $display("FAIL %s back_to_idle: hold %b jump %b addr %h want 0 0 000",
                     tag, hold_o, trap_jump_o, trap_csr_addr_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ld_en = 1'b0; ld_mstatus = 32'd0; ld_mtvec = 32'd0; ld_mepc = 32'd0;
        clear_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        hx_valid = 1'b1; illegal_i = 1'b1;
        #1;
        checks++;
        if (hold_o !== 1'b0 || trap_csr_we_o !== 1'b0 || trap_csr_addr_o !== 12'h000 ||
            trap_csr_wdata_o !== 32'd0 || trap_jump_o !== 1'b0 || trap_jump_addr_o !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs: hold %b we %b addr %h wdata %h jump %b jaddr %h want all 0",
                     hold_o, trap_csr_we_o, trap_csr_addr_o, trap_csr_wdata_o, trap_jump_o, trap_jump_addr_o);
        end
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_illegal();
        preload(32'h0000_0008, 32'h0000_0200, 32'd0);
        exercise_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                    32'h100, 32'h104, 32'hFFFF_FFFF, "illegal");
        checks++;
        if (csr_mstatus[3] !== 1'b0 || csr_mstatus[7] !== 1'b1) begin
            failures++;
            $display("FAIL illegal_mstatus: got %h want MIE=0 MPIE=1", csr_mstatus);
        end
    endtask

    task automatic test_vectored();
        preload(32'h0000_0008, 32'h0000_0301, 32'd0);
        exercise_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                    32'h40, 32'h44, 32'h0, "vectored_mti");
    endtask

    task automatic test_masked();
        int base;
        preload(32'h0000_0000, 32'h0000_0200, 32'd0);
        base = wlog.size();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            hx_valid = 1'($urandom_range(0, 1)); ex_trap_valid_i = 1'b1;
            #1;
            checks++;
            if (hold_o !== 1'b0 || trap_csr_we_o !== 1'b0) begin
                failures++;
                $display("FAIL masked cycle %0d: hold %b we %b want 0 0", i, hold_o, trap_csr_we_o);
            end
        end
        @(negedge clk);
        clear_inputs();
        checks++;
        if (wlog.size() != base) begin
            failures++;
            $display("FAIL masked_writes: got %0d want 0", wlog.size() - base);
        end
    endtask

    task automatic test_collision();
        preload(32'h0000_0008, 32'h0000_0400, 32'd0);
        exercise_op(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h500, 32'h504, 32'h0, "coll_ecall");
        exercise_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h600, 32'h604, 32'h0, "coll_mei_masked");
        exercise_op(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h700, 32'h704, 32'h0, "coll_mret");
        exercise_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h800, 32'h804, 32'h0, "coll_mei");
    endtask

    task automatic test_mret();
        preload(32'h0000_0080, 32'h0000_0200, 32'h0000_1234);
        exercise_op(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h24, 32'h0, "mret");
    endtask

    task automatic test_mid_reset();
        int base;
        logic [31:0] ms_before;
        preload(32'h0000_0008, 32'h0000_0200, 32'd0);
        ms_before = csr_mstatus;
        base = wlog.size();
        @(negedge clk);
        hx_valid = 1'b1; illegal_i = 1'b1; pc_i = 32'h900; inst_i = 32'hDEAD_BEEF;
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (hold_o !== 1'b0 || trap_csr_we_o !== 1'b0 || trap_csr_addr_o !== 12'h000 ||
            trap_csr_wdata_o !== 32'd0 || trap_jump_o !== 1'b0 || trap_jump_addr_o !== 32'd0) begin
            failures++;
            $display("FAIL midreset_outputs: hold %b we %b addr %h wdata %h jump %b jaddr %h want all 0",
                     hold_o, trap_csr_we_o, trap_csr_addr_o, trap_csr_wdata_o, trap_jump_o, trap_jump_addr_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (wlog.size() - base != 2) begin
            failures++;
            $display("FAIL midreset_count: got %0d want 2", wlog.size() - base);
        end else begin
            checks++;
            if (wlog[base].a !== 12'h341 || wlog[base + 1].a !== 12'h342) begin
                failures++;
                $display("FAIL midreset_addrs: got %h %h want 341 342", wlog[base].a, wlog[base + 1].a);
            end
        end
        checks++;
        if (csr_mtval !== 32'd0 || csr_mstatus !== ms_before) begin
            failures++;
            $display("FAIL midreset_csrs: mtval %h mstatus %h want 0 %h", csr_mtval, csr_mstatus, ms_before);
        end
    endtask

    task automatic test_random();
        logic [31:0] r, ms, tv;
        for (int i = 0; i < 60; i++) begin
            r  = $urandom;
            ms = $urandom;
            tv = {r[31:2], (($urandom_range(0, 1) == 1) ? 2'b01 : 2'b00)};
            preload(ms, tv, $urandom);
            exercise_op($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                        $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
                        $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                        $urandom_range(0, 2) == 0, $urandom, $urandom, $urandom, "random");
        end
    endtask

    initial begin
        test_reset();
        test_illegal();
        test_vectored();
        test_masked();
        test_collision();
        test_mret();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Trap sequencer that drives the initiator side of the CSR block's `trap_csr_*` channel. It accepts synchronous exceptions (ecall, ebreak, illegal instruction), gated interrupt requests and `mret`. On trap entry it writes `mepc`, `mcause`, `mtval` and `mstatus`, then redirects fetch to `mtvec`; on `mret` it restores `mstatus` and redirects to `mepc`. It sits beside idex in the core and stalls the pipeline while it owns the trap channel.

## Interface
Parameters:
- `VECTORED_EN`, default 1: when 1, interrupts honour `mtvec[1:0]==2'b01` vectored mode; when 0, `mtvec` is always treated as direct.

Ports:
- `clk`  in  1  core clock
- `rst_n`  in  1  reset, synchronous, active-low
- `hx_valid`  in  1  instruction retires this cycle; marks an instruction boundary
- `pc_i`  in  32  pc of the instruction currently in idex
- `next_pc_i`  in  32  pc the core would execute next
- `inst_i`  in  32  instruction word in idex; used as `mtval` for an illegal instruction
- `ecall_i`, `ebreak_i`, `illegal_i`  in  1 each  synchronous exception flags, valid with `hx_valid`
- `mret_i`  in  1  `mret` retiring, valid with `hx_valid`
- `ex_trap_valid_i`, `soft_trap_valid_i`, `tcmp_trap_valid_i`  in  1 each  interrupt requests, already masked by `mie`
- `mstatus_MIE3_i`  in  1  global interrupt enable
- `trap_csr_we_o`  out  1  CSR write strobe
- `trap_csr_addr_o`  out  12  CSR address
- `trap_csr_wdata_o`  out  32  CSR write data
- `trap_csr_rdata_i`  in  32  CSR read data; combinational from `trap_csr_addr_o`
- `hold_o`  out  1  stalls fetch and idex
- `trap_jump_o`  out  1  one-cycle fetch redirect
- `trap_jump_addr_o`  out  32  redirect target

## Operation
- States: IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, T_JUMP, R_MSTATUS, R_JUMP.
- Accept happens only in IDLE with `hx_valid=1`. Priority order: exception (illegal > ebreak > ecall) > `mret` > MEI > MSI > MTI.
- Interrupts are accepted only when `mstatus_MIE3_i=1`.
- At accept, latch `cause`, `epc` and `tval`:
  - illegal: cause 2, epc=`pc_i`, tval=`inst_i`
  - ebreak: cause 3, epc=`pc_i`, tval=`pc_i`
  - ecall: cause 11, epc=`pc_i`, tval=0
  - MEI: cause `32'h8000000B`, epc=`next_pc_i`, tval=0
  - MSI: cause `32'h80000003`, epc=`next_pc_i`, tval=0
  - MTI: cause `32'h80000007`, epc=`next_pc_i`, tval=0
- Trap path: IDLE → W_MEPC → W_MCAUSE → W_MTVAL → W_MSTATUS → T_JUMP → IDLE.
- W_MSTATUS computes the write combinationally from read data: wdata = rdata with bit7 = rdata[3] and bit3 = 0.
- T_JUMP reads `mtvec`. Target is `{mtvec[31:2],2'b00}`. If the trap is an interrupt, `VECTORED_EN=1` and `mtvec[1:0]==1`, the target is base + 4*cause[30:0].
- `mret` path: IDLE → R_MSTATUS → R_JUMP → IDLE.
  - R_MSTATUS writes rdata with bit3 = rdata[7] and bit7 = 1.
  - R_JUMP reads `mepc`; the target is `{mepc[31:2],2'b00}`.
- `trap_csr_addr_o` is 0 in IDLE. Write strobes occur only in the W_* states and R_MSTATUS.
- Arithmetic is 32-bit; overflow of the vectored target wraps silently.

## Timing
- Reset values: all outputs 0, state IDLE, latches 0.
- `rst_n` low in any state aborts the sequence on the next edge. Writes already issued stay issued; no further writes occur.
- Trap accepted at edge T: W_MEPC..W_MSTATUS occupy cycles T+1..T+4, and `trap_jump_o` is high for exactly cycle T+5.
- `mret` accepted at T: R_MSTATUS is cycle T+1; the jump is cycle T+2.
- `hold_o` is combinationally high in the accept cycle and in every non-IDLE state. It is low in IDLE otherwise.
- Integration contract: idex issues no CSR write while `hold_o=1`. The CSR block gives idex writes priority, so a collision would drop the trap write.
- Exception and interrupt in the same cycle: the exception is taken. Interrupts are level-sensitive and are re-evaluated once the FSM returns to IDLE.
- `mret` and interrupt in the same cycle: `mret` is taken.
- Inputs arriving while the FSM is busy are ignored.

## Structure
- CSR addresses (`CSR_MSTATUS` 12'h300, `CSR_MTVEC` 12'h305, `CSR_MEPC` 12'h341, `CSR_MCAUSE` 12'h342, `CSR_MTVAL` 12'h343) live in `defines.v`, along with `RegBus` and `CsrAddrBus`.
- Add cause-code and state-encoding constants to `defines.v`.
- Single module. Optional sub-module `trap_prio`: a combinational priority encoder that produces cause/epc/tval.

## Test plan
- Illegal instruction: `illegal_i=1`, `hx_valid=1`, `pc_i=0x100`, `inst_i=0xFFFFFFFF`, mtvec=0x200 → `mepc`=0x100, `mcause`=2, `mtval`=0xFFFFFFFF, `mstatus` MIE 1→0 and MPIE=1; jump to 0x200 at T+5; `hold_o` high T..T+5.
- Vectored interrupt: MTI with MIE=1, `next_pc_i=0x44`, mtvec=0x301 → `mcause`=0x80000007, `mepc`=0x44, jump to 0x31C.
- Interrupt masked: `mstatus_MIE3_i=0` with `ex_trap_valid_i=1` for 20 cycles → no write strobe, `hold_o` stays 0.
- Collision: ecall and MEI in the same cycle → `mcause`=11. MEI is taken after the first trap completes and MIE is restored by a subsequent `mret`.
- `mret`: mstatus=0x80, mepc=0x1234 → mstatus written 0x88, jump to 0x1234 at T+2.
- Mid-sequence reset: `rst_n` low in W_MCAUSE → next cycle is IDLE, all outputs 0, no `mtval`/`mstatus` write.
